// File: rtl/control_sequencer.sv
// Micro-step sequencer for a small accumulator CPU: fetch in T0/T1, execute in T2..T4, optional HALT.
// Strobes are combinational in state/opcode/flags (zero latency); enable=0 stalls the step and blanks strobes.
module control_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] opcode,
    input  logic       carry_flag_register,
    input  logic       zero_flag_register,
    output logic       PC_out,
    output logic       PC_inc,
    output logic       PC_load,
    output logic       MAR_load,
    output logic       RAM_out,
    output logic       RAM_in,
    output logic       IR_load,
    output logic       IR_out,
    output logic       A_load,
    output logic       A_out,
    output logic       B_load,
    output logic       ALU_out,
    output logic       ALU_sub,
    output logic       FR_read,
    output logic       OUT_load,
    output logic       halted,
    output logic [2:0] step
);

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t state;
    logic   known_op;
    logic   alu_op;
    logic   mem_op;
    logic   active;

    // Unlisted opcodes behave as NOP and end right after fetch.
    assign known_op = (opcode >= OP_LDA && opcode <= OP_JZ) || opcode == OP_OUT || opcode == OP_HLT;
    assign alu_op   = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign mem_op   = (opcode == OP_LDA) || alu_op || (opcode == OP_STA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= T0;
        end else if (state == HALT) begin
            state <= HALT;
        end else if (enable) begin
            case (state)
                T0:      state <= T1;
                T1:      state <= known_op ? T2 : T0;
                T2:      state <= (opcode == OP_HLT) ? HALT : (mem_op ? T3 : T0);
                T3:      state <= alu_op ? T4 : T0;
                default: state <= T0;
            endcase
        end
    end

    assign active = !reset && enable && (state != HALT);
    assign halted = (state == HALT) && !reset;
    assign step   = (state == HALT) ? 3'd0 : state;

    always_comb begin
        PC_out   = 1'b0;
        PC_inc   = 1'b0;
        PC_load  = 1'b0;
        MAR_load = 1'b0;
        RAM_out  = 1'b0;
        RAM_in   = 1'b0;
        IR_load  = 1'b0;
        IR_out   = 1'b0;
        A_load   = 1'b0;
        A_out    = 1'b0;
        B_load   = 1'b0;
        ALU_out  = 1'b0;
        ALU_sub  = 1'b0;
        FR_read  = 1'b0;
        OUT_load = 1'b0;
        if (active) begin
            case (state)
                T0: begin
                    PC_out   = 1'b1;
                    MAR_load = 1'b1;
                end
                T1: begin
                    RAM_out = 1'b1;
                    IR_load = 1'b1;
                    PC_inc  = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            IR_out   = 1'b1;
                            MAR_load = 1'b1;
                        end
                        OP_LDI: begin
                            IR_out = 1'b1;
                            A_load = 1'b1;
                        end
                        OP_JMP: begin
                            IR_out  = 1'b1;
                            PC_load = 1'b1;
                        end
                        // Flags are only looked at here, so changes elsewhere are harmless.
                        OP_JC: begin
                            IR_out  = carry_flag_register;
                            PC_load = carry_flag_register;
                        end
                        OP_JZ: begin
                            IR_out  = zero_flag_register;
                            PC_load = zero_flag_register;
                        end
                        OP_OUT: begin
                            A_out    = 1'b1;
                            OUT_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            RAM_out = 1'b1;
                            A_load  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            RAM_out = 1'b1;
                            B_load  = 1'b1;
                        end
                        OP_STA: begin
                            A_out  = 1'b1;
                            RAM_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (alu_op) begin
                        ALU_out = 1'b1;
                        A_load  = 1'b1;
                        FR_read = 1'b1;
                        ALU_sub = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
